// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: parity mode
//                codes, receiver state encoding and the clocks-per-bit helper.
//  Contents    : PARITY_NONE/EVEN/ODD, rx_state_t, uart_cpb()
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_PAR     = 3'd3,
        RX_STOP    = 3'd4,
        RX_BRKWAIT = 3'd5
    } rx_state_t;

    // Whole clk cycles per line bit.
    function automatic int uart_cpb(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Line front end for the UART receiver. Synchronises the raw
//                line, detects falling edges, runs the per-bit cycle counter
//                and produces a 3-sample mid-bit majority vote.
//  Ports       : clk, resetn        clock, async active-low reset
//                uart_rxd           raw serial line
//                cnt_clear          restart the bit counter at 0
//                cnt_run            let the bit counter advance
//                rxs                synchronised line
//                fall_edge          1->0 transition seen on rxs
//                vote, vote_strobe  majority value, valid while vote_strobe=1
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int BIT_RATE = 9600,
    parameter int CLK_HZ   = 100000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic uart_rxd,
    input  logic cnt_clear,
    input  logic cnt_run,
    output logic rxs,
    output logic fall_edge,
    output logic vote,
    output logic vote_strobe
);

    localparam int c_cpb  = uart_cpb(CLK_HZ, BIT_RATE);
    localparam int c_half = c_cpb / 2;
    localparam int c_cw   = $clog2(c_cpb + 1);

    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(c_cpb - 1);
    localparam logic [c_cw-1:0] c_s0       = c_cw'(c_half - 1);
    localparam logic [c_cw-1:0] c_s1       = c_cw'(c_half);
    localparam logic [c_cw-1:0] c_s2       = c_cw'(c_half + 1);

    logic [1:0]      r_sync;
    logic            r_rxs_d;
    logic [c_cw-1:0] r_cnt;
    logic            r_s0;
    logic            r_s1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= 2'b11;
            r_rxs_d <= 1'b1;
            r_cnt   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], uart_rxd};
            r_rxs_d <= r_sync[1];
            if (cnt_clear) begin
                r_cnt <= '0;
            end else if (cnt_run) begin
                r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            end
            if (cnt_run && (r_cnt == c_s0)) r_s0 <= r_sync[1];
            if (cnt_run && (r_cnt == c_s1)) r_s1 <= r_sync[1];
        end
    end

    assign rxs         = r_sync[1];
    assign fall_edge   = r_rxs_d & ~r_sync[1];
    // Third sample is taken live in the strobe cycle, so the vote needs no
    // extra register stage.
    assign vote_strobe = cnt_run && (r_cnt == c_s2);
    assign vote        = (r_s0 & r_s1) | (r_s0 & r_sync[1]) | (r_s1 & r_sync[1]);

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : Parametrised UART receiver: 5..9 data bits, none/even/odd
//                parity, 1 or 2 stop bits. Reports parity, framing, break and
//                overrun status and holds one word behind valid/ready.
//  Ports       : clk, resetn        clock, async active-low reset
//                uart_rxd           serial line (asynchronous)
//                uart_rx_en         enables detection of new start bits
//                uart_rx_valid      held word available
//                uart_rx_ready      consumer accepts when valid && ready
//                uart_rx_data       held word, LSB first on the line
//                uart_rx_perr       parity error on held word
//                uart_rx_ferr       framing error on held word
//                uart_rx_break      held word is a BREAK
//                uart_rx_overrun    frame(s) dropped while word held
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 100000000,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    input  logic                    uart_rx_ready,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun
);

    localparam int c_cpb = uart_cpb(CLK_HZ, BIT_RATE);
    localparam int c_bw  = $clog2(PAYLOAD_BITS);

    localparam logic [c_bw-1:0] c_bit_last  = c_bw'(PAYLOAD_BITS - 1);
    localparam logic            c_par_odd   = (PARITY == PARITY_ODD);
    localparam logic            c_has_par   = (PARITY != PARITY_NONE);
    localparam logic            c_stop_last = (STOP_BITS == 2);

    generate
        if (c_cpb < 8) begin : g_bad_cpb
            $error("uart_rx_frame: CLK_HZ/BIT_RATE must be at least 8");
        end
        if ((PAYLOAD_BITS < 5) || (PAYLOAD_BITS > 9)) begin : g_bad_payload
            $error("uart_rx_frame: PAYLOAD_BITS must be 5..9");
        end
        if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
            $error("uart_rx_frame: STOP_BITS must be 1 or 2");
        end
        if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
            $error("uart_rx_frame: PARITY must be 0, 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Line front end
    // ------------------------------------------------------------------
    logic w_rxs;
    logic w_fall_edge;
    logic w_vote;
    logic w_vote_strobe;
    logic w_cnt_clear;
    logic w_cnt_run;

    uart_rx_sampler #(
        .BIT_RATE (BIT_RATE),
        .CLK_HZ   (CLK_HZ)
    ) u_sampler (
        .clk         (clk),
        .resetn      (resetn),
        .uart_rxd    (uart_rxd),
        .cnt_clear   (w_cnt_clear),
        .cnt_run     (w_cnt_run),
        .rxs         (w_rxs),
        .fall_edge   (w_fall_edge),
        .vote        (w_vote),
        .vote_strobe (w_vote_strobe)
    );

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    rx_state_t               r_state;
    rx_state_t               w_state_nxt;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic [c_bw-1:0]         r_bit_idx;
    logic                    r_stop_idx;
    logic                    r_par_bit;
    logic                    r_perr;
    logic                    r_ferr;

    logic w_commit;
    logic w_ferr_fin;
    logic w_break;
    logic w_perr_fin;

    // Final flags include the stop vote being taken in the commit cycle.
    assign w_ferr_fin = r_ferr | ~w_vote;
    assign w_break    = (r_shift == '0) && !r_par_bit && w_ferr_fin;
    assign w_perr_fin = w_break ? 1'b0 : r_perr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= RX_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clear = 1'b0;
        w_cnt_run   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (uart_rx_en && w_fall_edge) begin
                    w_state_nxt = RX_START;
                    w_cnt_clear = 1'b1;
                end
            end
            RX_START: begin
                w_cnt_run = 1'b1;
                if (w_vote_strobe) w_state_nxt = w_vote ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                w_cnt_run = 1'b1;
                if (w_vote_strobe && (r_bit_idx == c_bit_last))
                    w_state_nxt = c_has_par ? RX_PAR : RX_STOP;
            end
            RX_PAR: begin
                w_cnt_run = 1'b1;
                if (w_vote_strobe) w_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                w_cnt_run = 1'b1;
                // Commit at the last stop vote so the next start edge,
                // which may follow the stop bit directly, is not missed.
                if (w_vote_strobe && (r_stop_idx == c_stop_last)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = w_break ? RX_BRKWAIT : RX_IDLE;
                end
            end
            RX_BRKWAIT: begin
                if (w_rxs) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else if (w_vote_strobe) begin
            case (r_state)
                RX_START: begin
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_par_bit  <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                end
                RX_DATA: begin
                    r_shift   <= {w_vote, r_shift[PAYLOAD_BITS-1:1]};
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
                RX_PAR: begin
                    r_par_bit <= w_vote;
                    r_perr    <= ((^r_shift) ^ w_vote) != c_par_odd;
                end
                RX_STOP: begin
                    if (!w_vote) r_ferr <= 1'b1;
                    r_stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-entry output buffer
    // ------------------------------------------------------------------
    logic                    r_valid;
    logic [PAYLOAD_BITS-1:0] r_data;
    logic                    r_out_perr;
    logic                    r_out_ferr;
    logic                    r_out_break;
    logic                    r_overrun;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_out_perr  <= 1'b0;
            r_out_ferr  <= 1'b0;
            r_out_break <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_commit) begin
            if (!r_valid || uart_rx_ready) begin
                r_valid     <= 1'b1;
                r_data      <= r_shift;
                r_out_perr  <= w_perr_fin;
                r_out_ferr  <= w_ferr_fin;
                r_out_break <= w_break;
                r_overrun   <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && uart_rx_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign uart_rx_valid   = r_valid;
    assign uart_rx_data    = r_data;
    assign uart_rx_perr    = r_out_perr;
    assign uart_rx_ferr    = r_out_ferr;
    assign uart_rx_break   = r_out_break;
    assign uart_rx_overrun = r_overrun;

endmodule
`default_nettype wire
